// File: rtl/ila_buffer_reader.sv
// Streaming readout of the ILA sample buffer onto a valid/ready stream, one beat per DATA_W slice.
// Define ILA_READER_HEADER_EN to prefix the readout with a sample-count header beat.
module ila_buffer_reader #(
  parameter  int DATA_W   = 32,
  parameter  int SIGNAL_W = 32,
  parameter  int BUFFER_W = 10,
  parameter  int READ_LAT = 2,
  localparam int WORDS    = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int SEL_W    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [BUFFER_W-1:0] samples_i,
  output logic [BUFFER_W-1:0] index_o,
  output logic [SEL_W-1:0]    value_select_o,
  input  logic [DATA_W-1:0]   value_i,
  output logic [DATA_W-1:0]   m_tdata_o,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
`ifdef ILA_READER_HEADER_EN
    HDR,
`endif
    ISSUE,
    WAIT,
    SEND
  } state_t;

  state_t              state_q;
  logic [BUFFER_W-1:0] n_lat_q;
  logic [BUFFER_W-1:0] idx_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   tdata_q;
  logic                tvalid_q;
  logic                tlast_q;
  logic                busy_q;
  logic                done_q;
  logic                last_d;

  always_comb begin
    last_d = (idx_q == n_lat_q - BUFFER_W'(1)) && (sel_q == SEL_LAST);
  end

  // idx_q/sel_q only change when entering ISSUE, so they double as the registered read port.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      n_lat_q  <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (cke_i) begin
      done_q <= 1'b0;
      if (abort_i && (state_q != IDLE)) begin
        state_q  <= IDLE;
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              n_lat_q <= samples_i;
              idx_q   <= '0;
              sel_q   <= '0;
`ifdef ILA_READER_HEADER_EN
              state_q  <= HDR;
              busy_q   <= 1'b1;
              tdata_q  <= DATA_W'(samples_i);
              tvalid_q <= 1'b1;
              tlast_q  <= (samples_i == '0);
`else
              if (samples_i == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= ISSUE;
                busy_q  <= 1'b1;
              end
`endif
            end
          end
`ifdef ILA_READER_HEADER_EN
          HDR: begin
            if (m_tready_i) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              if (tlast_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ISSUE;
              end
            end
          end
`endif
          ISSUE: begin
            cnt_q   <= CNT_W'(READ_LAT);
            state_q <= WAIT;
          end
          WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
              tdata_q  <= value_i;
              tvalid_q <= 1'b1;
              tlast_q  <= last_d;
              state_q  <= SEND;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          SEND: begin
            if (m_tready_i) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              if (tlast_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if (sel_q == SEL_LAST) begin
                sel_q   <= '0;
                idx_q   <= idx_q + BUFFER_W'(1);
                state_q <= ISSUE;
              end else begin
                sel_q   <= sel_q + SEL_W'(1);
                state_q <= ISSUE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign index_o        = idx_q;
  assign value_select_o = sel_q;
  assign m_tdata_o      = tdata_q;
  assign m_tvalid_o     = tvalid_q;
  assign m_tlast_o      = tlast_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
